// File: rtl/lc3_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// lc3_bus_arbiter_if
//   Bundle of signals between the tristate bus drivers and the bus arbiter.
//
//   req      : per-driver bus request, held high while the driver wants the bus
//   gate_en  : per-driver tristate enable, at most one bit high
//   owner    : index of the enabled driver, 0 when none is enabled
//   bus_idle : high when no driver is enabled
//   timeout  : one-cycle pulse when an ownership was cut off by the hold limit
//
//   Modports:
//     master : the requester side (drives req, observes the grant outputs)
//     slave  : the arbiter side (samples req, drives the grant outputs)
// -----------------------------------------------------------------------------
interface lc3_bus_arbiter_if #(
  parameter int N = 4
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic [N-1:0]  gate_en;
  logic [OW-1:0] owner;
  logic          bus_idle;
  logic          timeout;

  modport master (
    output req,
    input  gate_en,
    input  owner,
    input  bus_idle,
    input  timeout
  );

  modport slave (
    input  req,
    output gate_en,
    output owner,
    output bus_idle,
    output timeout
  );
endinterface

// File: rtl/lc3_bus_arbiter.sv
// -----------------------------------------------------------------------------
// lc3_bus_arbiter
//   Round-robin owner selection for a shared tristate bus. Exactly zero or one
//   driver is enabled per cycle, each ownership is capped at MAX_HOLD cycles,
//   and every hand-over is separated by TURN_CYC dead cycles so that two
//   drivers never fight on the wires.
//
//   Parameters:
//     N        : number of bus drivers (requesters)
//     MAX_HOLD : maximum consecutive cycles one owner may drive the bus
//     TURN_CYC : dead cycles between owners (>= 1)
//
//   Ports:
//     clk   : clock, all state changes on its rising edge
//     rst_n : asynchronous active-low reset
//     bus   : slave side of lc3_bus_arbiter_if (req in; gate_en, owner,
//             bus_idle, timeout out). The interface N must match this N.
// -----------------------------------------------------------------------------
module lc3_bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int TURN_CYC = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  lc3_bus_arbiter_if.slave    bus
);

  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = (TURN_CYC > 0) ? $clog2(TURN_CYC + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t        state_q,   state_d;
  logic [N-1:0]  gate_en_q, gate_en_d;
  logic [OW-1:0] owner_q,   owner_d;
  logic [OW-1:0] last_q,    last_d;
  logic [HW-1:0] hold_q,    hold_d;
  logic [TW-1:0] turn_q,    turn_d;
  logic          timeout_q, timeout_d;

  logic          win_vld;
  logic [OW-1:0] win;

  // Round-robin pick: search last+1, last+2, ... modulo N. The loop runs from
  // the far end toward last+1 so the nearest requester overwrites the result.
  // The previous owner is searched last, which gives a timed-out owner the
  // lowest priority automatically.
  function automatic logic [OW:0] rr_pick(input logic [N-1:0]  r,
                                          input logic [OW-1:0] l);
    logic [OW:0]   res;
    logic [OW-1:0] iw;
    int            idx;
    res = '0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(l) + k) % N;
      iw  = idx[OW-1:0];
      if (r[iw]) begin
        res = {1'b1, iw};
      end
    end
    return res;
  endfunction

  always_comb begin
    {win_vld, win} = rr_pick(bus.req, last_q);
  end

  always_comb begin
    state_d   = state_q;
    gate_en_d = gate_en_q;
    owner_d   = owner_q;
    last_d    = last_q;
    hold_d    = hold_q;
    turn_d    = turn_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d   = DRIVE;
          gate_en_d = N'(1) << win;
          owner_d   = win;
          last_d    = win;
          hold_d    = HW'(1);
          turn_d    = '0;
        end
      end

      DRIVE: begin
        // A release on the limit edge counts as a normal release, so the
        // request check takes precedence over the hold limit.
        if (!bus.req[owner_q]) begin
          state_d   = TURN;
          gate_en_d = '0;
          owner_d   = '0;
          hold_d    = '0;
          turn_d    = TW'(1);
        end else if (hold_q == HW'(MAX_HOLD)) begin
          state_d   = TURN;
          gate_en_d = '0;
          owner_d   = '0;
          hold_d    = '0;
          turn_d    = TW'(1);
          timeout_d = 1'b1;
        end else begin
          hold_d    = hold_q + HW'(1);
        end
      end

      TURN: begin
        // turn_q counts dead cycles already shown; re-arbitrate on the edge
        // that closes the last one.
        if (turn_q == TW'(TURN_CYC)) begin
          turn_d = '0;
          if (win_vld) begin
            state_d   = DRIVE;
            gate_en_d = N'(1) << win;
            owner_d   = win;
            last_d    = win;
            hold_d    = HW'(1);
          end else begin
            state_d   = IDLE;
          end
        end else begin
          turn_d = turn_q + TW'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        gate_en_d = '0;
        owner_d   = '0;
        hold_d    = '0;
        turn_d    = '0;
      end
    endcase
  end

  // Asynchronous clear so a reset mid-DRIVE drops the tristate enable at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gate_en_q <= '0;
      owner_q   <= '0;
      last_q    <= OW'(N - 1);
      hold_q    <= '0;
      turn_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_en_q <= gate_en_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      turn_q    <= turn_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gate_en  = gate_en_q;
  assign bus.owner    = owner_q;
  assign bus.bus_idle = ~|gate_en_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: doc/lc3_bus_arbiter.md
LC3_BUS_ARBITER -- requirements
Module: lc3_bus_arbiter

Interface
REQ-001 The module SHALL have parameter N, default 4, giving the number of tristate bus drivers (requesters).
REQ-002 The module SHALL have parameter MAX_HOLD, default 8, giving the maximum number of consecutive cycles one owner may drive the bus.
REQ-003 The module SHALL have parameter TURN_CYC, default 1, giving the number of dead cycles with no driver enabled between owners (at least 1).
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have port req, input, N bits: per-driver bus request, held high while the driver wants the bus.
REQ-007 The module SHALL have port gate_en, output, N bits: registered per-driver tristate enable, at most one bit high.
REQ-008 The module SHALL have port owner, output, clog2(N) bits: index of the enabled driver, 0 when none is enabled.
REQ-009 The module SHALL have port bus_idle, output, 1 bit: high when gate_en is all zero.
REQ-010 The module SHALL have port timeout, output, 1 bit: one-cycle pulse when an ownership is ended by the MAX_HOLD limit.

Function
REQ-011 The block SHALL implement a state machine with three states: IDLE, DRIVE and TURN.
REQ-012 IDLE: on a clock edge with req nonzero, the block SHALL select a winner by round-robin, set gate_en to one-hot(winner) and enter DRIVE; gate_en is visible after that same edge.
REQ-013 Round-robin SHALL search indices last+1, last+2, ... modulo N, where last is the previous owner; at reset last = N-1, so index 0 wins first.
REQ-014 DRIVE: gate_en SHALL stay equal to one-hot(owner) and a hold counter SHALL increment every cycle, starting at 1 in the first DRIVE cycle.
REQ-015 DRIVE SHALL end at the edge where req[owner] is sampled low; gate_en then goes all zero and the block enters TURN.
REQ-016 DRIVE SHALL also end at the edge where the hold counter equals MAX_HOLD with req[owner] still high; gate_en goes zero, timeout pulses high for exactly the next cycle, and the block enters TURN.
REQ-017 If req[owner] drops on the same edge as the MAX_HOLD limit, the release SHALL be treated as normal and timeout SHALL stay low.
REQ-018 TURN SHALL last exactly TURN_CYC cycles with gate_en all zero, whatever the req value.
REQ-019 At the end of TURN, if req is nonzero the block SHALL arbitrate as in IDLE and enter DRIVE directly; otherwise it SHALL enter IDLE.
REQ-020 A timed-out owner still requesting SHALL get the lowest round-robin priority; it is re-granted only if no other req bit is high.
REQ-021 The block SHALL ignore req bits of non-owners during DRIVE and TURN; only the arbitration edge samples them.
REQ-022 The block SHALL NOT enable two drivers in the same cycle, and SHALL NOT pass ownership between drivers without at least TURN_CYC all-zero cycles.
REQ-023 owner SHALL be the registered index matching gate_en; bus_idle SHALL equal ~|gate_en.

Reset
REQ-024 While rst_n is low, asynchronously: gate_en = 0, owner = 0, bus_idle = 1, timeout = 0, state = IDLE, hold counter = 0, last = N-1.
REQ-025 Assertion of rst_n during DRIVE SHALL disable the driver immediately, without waiting for a clock edge; after release the block starts from IDLE with index 0 first in priority.

Verification (N=4, MAX_HOLD=8, TURN_CYC=1)
REQ-026 A bench SHALL check: req=0001 from idle -> gate_en=0001 after the next edge; req dropped -> 0000 for 1 cycle -> bus_idle=1.
REQ-027 A bench SHALL check: req=1111 held -> grants in order 0,1,2,3,0, each DRIVE 8 cycles, each followed by timeout=1 and 1 dead cycle.
REQ-028 A bench SHALL check: req=0110 with owner 1 releasing after 3 cycles -> gate_en 0010 x3, 0000 x1, then 0100.
REQ-029 A bench SHALL check: req[owner] dropped on the 8th DRIVE cycle -> timeout stays 0.
REQ-030 A bench SHALL check: rst_n low mid-DRIVE (gate_en=0100) -> gate_en=0000 before the next edge; after release with req=1100 -> index 2 is granted.
REQ-031 A bench SHALL check, as a continuous assertion over a random-req run of at least 1000 cycles: $onehot0(gate_en) holds every cycle, and no cycle changes gate_en directly from one nonzero value to a different nonzero value.
